pdm_cic_decimator: RTL and testbench
====================================

Name: pdm_cic_decimator

Overview:
- Front-end stage of the beamformer: converts raw 1-bit PDM microphone streams into signed PCM samples.
- Runs a 3rd-order CIC decimator per channel. Integrators run on every clock; combs are evaluated serially, one channel per handshake.
- Produces a time-multiplexed valid/ready PCM stream (channel index plus sample) that the delay-and-sum core consumes.

Parameters:
- CHANNELS, 8, number of PDM inputs (1..16).
- DECIM, 64, decimation ratio; power of two, 4..256.
- OUT_W, 16, output sample width; must be ≤ ACC_W−2.
- ACC_W (localparam) = 3*log2(DECIM)+1, accumulator width (19 at defaults).

Ports:
- clk  in  1  PDM bit clock; the only clock.
- rst  in  1  synchronous reset, active-high.
- pdm_in  in  CHANNELS  PDM bits, one per channel, sampled every clk.
- dec_in  in  1  external decimation strobe source; used only with CIC_EXT_DEC_EN.
- pcm_valid  out  1  output sample valid.
- pcm_ready  in  1  consumer accepts sample this cycle.
- pcm_ch  out  log2(CHANNELS) (min 1)  channel index of pcm_data.
- pcm_data  out  OUT_W  signed PCM sample.
- frame_start  out  1  high while pcm_valid and pcm_ch==0.
- overrun  out  1  sticky: a decimation tick was dropped.

Behaviour:
- Reset (clk edge with rst=1):
  - Integrators, comb delay registers, snapshots, decimation counter cleared.
  - State ← IDLE.
  - pcm_valid=0, pcm_ch=0, pcm_data=0, frame_start=0, overrun=0.
- Input mapping: pdm_in bit treated as unsigned 0/1.
- Integrators: 3 cascaded per channel, updated every cycle including during DRAIN.
  - Modular ACC_W arithmetic; wrap-around is required and harmless.
- Tick generation: counter 0..DECIM−1. Tick is the cycle the counter equals DECIM−1; the counter then wraps to 0. The first tick occurs DECIM cycles after reset release.
- State machine IDLE/DRAIN:
  - IDLE + tick: snapshot each channel's 3rd integrator; ch←0; →DRAIN.
  - DRAIN: compute the 3-stage comb for channel ch using its snapshot and per-channel delay registers (modular ACC_W subtraction).
    - Result r = (comb − 2^(ACC_W−2)) >>> (ACC_W−OUT_W), arithmetic shift, truncating.
    - r is loaded into the output register when it is empty or being accepted.
    - That channel's comb delay registers update only when r is loaded.
  - Last channel loaded → IDLE.
- Timing:
  - pcm_valid first rises 2 cycles after the tick cycle, with pcm_ch=0.
  - With pcm_ready held high: channels 0..CHANNELS−1 on consecutive cycles, no bubbles.
- Handshake:
  - pcm_ch and pcm_data are held stable while pcm_valid && !pcm_ready.
  - pcm_valid drops the cycle after the last accepted channel if nothing is pending.
- Tick while in DRAIN, or with the output register still holding data:
  - Tick dropped, no snapshot taken, overrun←1 (sticky until rst).
  - Integrators keep running.
- Start-up: the first 3 frames after reset are comb transients. Values from frame 4 onward are exact.
- Full-scale values at defaults (frame ≥4):
  - All-ones input → comb 262144 → r=+16384.
  - All-zeros input → r=−16384.
  - 50% density → r=0.
- Reset mid-DRAIN: outputs clear the next edge; any partially drained frame is discarded.

Optional Feature:
- Macro CIC_EXT_DEC_EN.
- Defined:
  - Tick = rising edge of dec_in, detected with one register, so the tick is the cycle after dec_in goes 0→1.
  - Internal counter removed.
  - Ticks closer than CHANNELS+2 cycles apart set overrun per the drop rule.
- Undefined: internal counter generates ticks; dec_in is unused (tie-off only).

Test Plan:
- Reset then all pdm_in=1, pcm_ready=1, defaults → from frame 4: pcm_data=0x4000 for ch 0..7 on 8 consecutive cycles; frame_start only on ch0; overrun=0.
- pdm_in ch0 all 0, ch1 alternating 1/0, others 1 → steady state: ch0=0xC000, ch1=0x0000, others=0x4000.
- pcm_ready low 5 cycles mid-frame at ch3 → ch3 and its data held stable; ch4..7 follow on release; no overrun with 64-cycle ticks.
- pcm_ready held low for 100 cycles → next tick dropped; overrun=1 and stays 1; after release the remaining channels drain correctly.
- Assert rst during DRAIN at ch5 → next cycle pcm_valid=0 and overrun=0; first new pcm_valid at cycle 66 after reset release (64 to tick + 2).
- With CIC_EXT_DEC_EN: dec_in pulse every 64 cycles → same outputs as the default build; pulses 6 cycles apart → overrun=1.

Source files
------------

// File: rtl/pdm_cic_decimator.sv
// Per-channel 3rd-order CIC decimator turning 1-bit PDM streams into a time-multiplexed PCM stream.
// Optional build macro CIC_EXT_DEC_EN: decimation ticks come from rising edges of dec_in.
module pdm_cic_decimator #(
    parameter int CHANNELS = 8,
    parameter int DECIM    = 64,
    parameter int OUT_W    = 16,
    localparam int ACC_W   = 3 * $clog2(DECIM) + 1,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CHANNELS-1:0]     pdm_in,
    input  logic                    dec_in,
    output logic                    pcm_valid,
    input  logic                    pcm_ready,
    output logic [CH_W-1:0]         pcm_ch,
    output logic signed [OUT_W-1:0] pcm_data,
    output logic                    frame_start,
    output logic                    overrun
);

    typedef enum logic {IDLE, DRAIN} state_t;

    logic [ACC_W-1:0] int1_q [CHANNELS];
    logic [ACC_W-1:0] int2_q [CHANNELS];
    logic [ACC_W-1:0] int3_q [CHANNELS];
    logic [ACC_W-1:0] snap_q [CHANNELS];
    logic [ACC_W-1:0] d1_q   [CHANNELS];
    logic [ACC_W-1:0] d2_q   [CHANNELS];
    logic [ACC_W-1:0] d3_q   [CHANNELS];

    state_t                  state_q, state_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic                    out_valid_q, out_valid_d;
    logic [CH_W-1:0]         out_ch_q, out_ch_d;
    logic signed [OUT_W-1:0] out_data_q, out_data_d;
    logic                    overrun_q, overrun_d;
    logic                    tick, snap_en, load;
    logic [ACC_W-1:0]        c1, c2, c3;

    // Removes the unipolar mid-scale offset, then keeps the top OUT_W bits (truncating arithmetic shift).
    function automatic logic signed [OUT_W-1:0] scale_comb(input logic [ACC_W-1:0] comb);
        logic signed [ACC_W-1:0] centred;
        centred = signed'(comb - (ACC_W'(1) << (ACC_W - 2)));
        return centred[ACC_W-1:ACC_W-OUT_W];
    endfunction

`ifdef CIC_EXT_DEC_EN
    logic dec_q, tick_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            dec_q  <= dec_in;
            tick_q <= dec_in & ~dec_q;
        end
    end

    assign tick = tick_q;
`else
    localparam int CNT_W = $clog2(DECIM);
    logic [CNT_W-1:0] cnt_q;
    logic             unused_dec;

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_q + CNT_W'(1);
    end

    assign tick       = (cnt_q == CNT_W'(DECIM - 1));
    assign unused_dec = dec_in;
`endif

    // Integrator stage: free-running every clock, wrap-around cancels in the combs.
    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (rst) begin
                int1_q[c] <= '0;
                int2_q[c] <= '0;
                int3_q[c] <= '0;
            end else begin
                int1_q[c] <= int1_q[c] + {{(ACC_W-1){1'b0}}, pdm_in[c]};
                int2_q[c] <= int2_q[c] + int1_q[c];
                int3_q[c] <= int3_q[c] + int2_q[c];
            end
        end
    end

    always_comb begin
        c1 = snap_q[ch_q] - d1_q[ch_q];
        c2 = c1 - d2_q[ch_q];
        c3 = c2 - d3_q[ch_q];
    end

    assign load = (state_q == DRAIN) && (!out_valid_q || pcm_ready);

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        out_valid_d = out_valid_q && !pcm_ready;
        out_ch_d    = out_ch_q;
        out_data_d  = out_data_q;
        overrun_d   = overrun_q;
        snap_en     = 1'b0;
        if (tick) begin
            if (state_q == IDLE && !out_valid_q) begin
                snap_en = 1'b1;
                ch_d    = '0;
                state_d = DRAIN;
            end else begin
                overrun_d = 1'b1;
            end
        end
        if (load) begin
            out_valid_d = 1'b1;
            out_ch_d    = ch_q;
            out_data_d  = scale_comb(c3);
            ch_d        = ch_q + CH_W'(1);
            if (ch_q == CH_W'(CHANNELS - 1)) begin
                ch_d    = '0;
                state_d = IDLE;
            end
        end
    end

    // Snapshot / comb-delay stage: a channel's delays advance only when its result is loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                snap_q[c] <= '0;
                d1_q[c]   <= '0;
                d2_q[c]   <= '0;
                d3_q[c]   <= '0;
            end
        end else begin
            if (snap_en) begin
                for (int c = 0; c < CHANNELS; c++) snap_q[c] <= int3_q[c];
            end
            if (load) begin
                d1_q[ch_q] <= snap_q[ch_q];
                d2_q[ch_q] <= c1;
                d3_q[ch_q] <= c2;
            end
        end
    end

    // Output register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_data_q  <= out_data_d;
            overrun_q   <= overrun_d;
        end
    end

    assign pcm_valid   = out_valid_q;
    assign pcm_ch      = out_ch_q;
    assign pcm_data    = out_data_q;
    assign frame_start = out_valid_q && (out_ch_q == '0);
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Directed bench for pdm_cic_decimator at default parameters: full-scale vectors, latency, handshake and overrun.
module tb_pdm_cic_decimator;

    logic               clk = 1'b0;
    logic               rst;
    logic [7:0]         pdm_in;
    logic               dec_in;
    logic               pcm_valid;
    logic               pcm_ready;
    logic [2:0]         pcm_ch;
    logic signed [15:0] pcm_data;
    logic               frame_start;
    logic               overrun;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] ones_mask = 8'h00;
    logic [7:0] alt_mask  = 8'h00;
    logic       phase = 1'b0;

    typedef struct {
        string        name;
        logic [7:0]   ones;
        logic [7:0]   alt;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs[5];

    pdm_cic_decimator dut (
        .clk        (clk),
        .rst        (rst),
        .pdm_in     (pdm_in),
        .dec_in     (dec_in),
        .pcm_valid  (pcm_valid),
        .pcm_ready  (pcm_ready),
        .pcm_ch     (pcm_ch),
        .pcm_data   (pcm_data),
        .frame_start(frame_start),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // PDM source: constant-one channels plus channels toggling 1/0 every clock.
    initial begin
        pdm_in = 8'h00;
        forever begin
            @(negedge clk);
            pdm_in = ones_mask | (alt_mask & {8{phase}});
            phase  = ~phase;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        pcm_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_frame0(output bit ok);
        int n = 0;
        while (!(pcm_valid && pcm_ch == 3'd0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        ok = pcm_valid && (pcm_ch == 3'd0);
        if (!ok) chk("wait_frame0_timeout", 32'd0, 32'd1);
    endtask

    task automatic capture(input bit do_check, input string tag, output logic [127:0] data);
        bit ok;
        data = '0;
        wait_frame0(ok);
        if (ok) begin
            for (int i = 0; i < 8; i++) begin
                if (i > 0) @(negedge clk);
                data[i*16 +: 16] = pcm_data[15:0];
                if (do_check) begin
                    chk({tag, " valid"}, 32'(pcm_valid), 32'd1);
                    chk({tag, " ch"}, 32'(pcm_ch), 32'(i));
                    chk({tag, " frame_start"}, 32'(frame_start), (i == 0) ? 32'd1 : 32'd0);
                end
            end
        end
    endtask

    task automatic check_latency(input string tag);
        int c = 1;
        while (!pcm_valid && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk({tag, " first_valid_cycle"}, 32'(c), 32'd66);
        chk({tag, " first_ch"}, 32'(pcm_ch), 32'd0);
    endtask

    initial begin
        logic [127:0] frame;
        bit           ok;
        int           n;

        vecs[0] = '{"all_ones",  8'hFF, 8'h00, {8{16'h4000}}};
        vecs[1] = '{"all_zeros", 8'h00, 8'h00, {8{16'hC000}}};
        vecs[2] = '{"mixed",     8'hFC, 8'h02, {{6{16'h4000}}, 16'h0000, 16'hC000}};
        vecs[3] = '{"all_alt",   8'h00, 8'hFF, {8{16'h0000}}};
        vecs[4] = '{"interleave", 8'h55, 8'h80,
                    {16'h0000, 16'h4000, 16'hC000, 16'h4000, 16'hC000, 16'h4000, 16'hC000, 16'h4000}};

        rst       = 1'b1;
        pcm_ready = 1'b1;
        dec_in    = 1'b0;

        do_reset();
        chk("reset pcm_valid", 32'(pcm_valid), 32'd0);
        chk("reset pcm_ch", 32'(pcm_ch), 32'd0);
        chk("reset pcm_data", 32'(pcm_data[15:0]), 32'd0);
        chk("reset frame_start", 32'(frame_start), 32'd0);
        chk("reset overrun", 32'(overrun), 32'd0);
        check_latency("startup");

        foreach (vecs[v]) begin
            ones_mask = vecs[v].ones;
            alt_mask  = vecs[v].alt;
            do_reset();
            repeat (3) capture(1'b0, vecs[v].name, frame);
            capture(1'b1, vecs[v].name, frame);
            for (int i = 0; i < 8; i++)
                chk($sformatf("%s data ch%0d", vecs[v].name, i),
                    32'(frame[i*16 +: 16]), 32'(vecs[v].exp[i*16 +: 16]));
            chk({vecs[v].name, " overrun"}, 32'(overrun), 32'd0);
        end

        // Short stall at channel 3.
        ones_mask = 8'hFF;
        alt_mask  = 8'h00;
        do_reset();
        repeat (3) capture(1'b0, "warmup", frame);
        wait_frame0(ok);
        n = 0;
        while (pcm_ch != 3'd3 && n < 10) begin
            @(negedge clk);
            n++;
        end
        pcm_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall%0d ch", k), 32'(pcm_ch), 32'd3);
            chk($sformatf("stall%0d data", k), 32'(pcm_data[15:0]), 32'h4000);
            @(negedge clk);
        end
        chk("stall release ch", 32'(pcm_ch), 32'd3);
        chk("stall release valid", 32'(pcm_valid), 32'd1);
        pcm_ready = 1'b1;
        for (int i = 4; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("post_stall ch%0d valid", i), 32'(pcm_valid), 32'd1);
            chk($sformatf("post_stall ch%0d ch", i), 32'(pcm_ch), 32'(i));
            chk($sformatf("post_stall ch%0d data", i), 32'(pcm_data[15:0]), 32'h4000);
        end
        chk("short_stall overrun", 32'(overrun), 32'd0);
        capture(1'b1, "after_stall", frame);
        for (int i = 0; i < 8; i++)
            chk($sformatf("after_stall data ch%0d", i), 32'(frame[i*16 +: 16]), 32'h4000);

        // Long stall: the next tick lands while the frame is still pending.
        wait_frame0(ok);
        pcm_ready = 1'b0;
        repeat (100) @(negedge clk);
        chk("long_stall overrun", 32'(overrun), 32'd1);
        chk("long_stall held ch", 32'(pcm_ch), 32'd0);
        chk("long_stall held data", 32'(pcm_data[15:0]), 32'h4000);
        pcm_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("long_drain ch%0d", i), 32'(pcm_ch), 32'(i));
            chk($sformatf("long_drain data%0d", i), 32'(pcm_data[15:0]), 32'h4000);
        end
        repeat (150) @(negedge clk);
        chk("overrun sticky", 32'(overrun), 32'd1);

        // Reset asserted while channel 5 is on the output.
        wait_frame0(ok);
        n = 0;
        while (pcm_ch != 3'd5 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("pre_reset ch", 32'(pcm_ch), 32'd5);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_reset pcm_valid", 32'(pcm_valid), 32'd0);
        chk("mid_reset overrun", 32'(overrun), 32'd0);
        chk("mid_reset frame_start", 32'(frame_start), 32'd0);
        rst = 1'b0;
        check_latency("after_mid_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
